// File: rtl/dsc_par_acc.sv
// rtl/dsc_par_acc.sv - windowed ones-count accumulator over parallel stochastic bit lanes
// Purpose: sums popcount(data_in) over a window of win_len valid samples and
//   presents the total with a valid/ready handshake.
// Ports:
//   clk        - single clock, all state changes on posedge
//   rst        - asynchronous active-high reset
//   start      - open a new window (honoured in IDLE only)
//   win_len    - number of valid samples in the window, captured with start
//   data_in    - one stochastic bit per lane
//   in_valid   - data_in carries a sample this cycle
//   res_ready  - consumer accepts the result
//   busy       - high whenever the FSM is not IDLE
//   res_valid  - result valid, high only in HOLD
//   countval   - accumulated ones count
//   overflow   - sticky, the true sum exceeded 2^WIDTH-1 in this window
// Build option: DSC_ACC_SAT_EN - countval clamps at 2^WIDTH-1 instead of wrapping.
module dsc_par_acc #(
  parameter int LANES = 8,
  parameter int WIDTH = 10,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [LANES-1:0] data_in,
  input  logic             in_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] countval,
  output logic             overflow
);
  localparam int PW = $clog2(LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_HOLD} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_res_valid;
  logic             r_ovf;
  logic             r_pend;
  logic [WIDTH-1:0] r_count;
  logic [WIN_W-1:0] r_remaining;
  logic [PW-1:0]    r_pop;

  logic [PW-1:0]    w_pop;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_count;
  logic             w_acc_ovf;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + PW'(data_in[i]);
    end
  end

  // One extra bit so the carry out of the accumulator is visible.
  assign w_sum     = {1'b0, r_count} + (WIDTH + 1)'(r_pop);
  assign w_acc_ovf = r_ovf | w_sum[WIDTH];

`ifdef DSC_ACC_SAT_EN
  // Once saturated, stay pinned at full scale for the rest of the window.
  assign w_acc_count = w_acc_ovf ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
  assign w_acc_count = w_sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_pend      <= 1'b0;
      r_count     <= '0;
      r_remaining <= '0;
      r_pop       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining <= win_len;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_pop       <= '0;
            r_pend      <= 1'b0;
            r_busy      <= 1'b1;
            if (win_len == '0) begin
              r_state     <= S_HOLD;
              r_res_valid <= 1'b1;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          // Popcount is registered one edge, added the next.
          if (r_pend) begin
            r_count <= w_acc_count;
            r_ovf   <= w_acc_ovf;
          end
          if (in_valid) begin
            r_pop       <= w_pop;
            r_pend      <= 1'b1;
            r_remaining <= r_remaining - WIN_W'(1);
            if (r_remaining == WIN_W'(1)) begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_pend <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_pend) begin
            r_count <= w_acc_count;
            r_ovf   <= w_acc_ovf;
          end
          r_pend      <= 1'b0;
          r_state     <= S_HOLD;
          r_res_valid <= 1'b1;
        end
        S_HOLD: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign countval  = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_dsc_par_acc.sv
// tb/tb_dsc_par_acc.sv - self-checking bench for dsc_par_acc (WIDTH=10 and WIDTH=5 instances)
module tb_dsc_par_acc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] win_len = '0;
  logic [7:0] data_in = '0;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;

  logic       busy_a, res_valid_a, overflow_a;
  logic [9:0] countval_a;
  logic       busy_b, res_valid_b, overflow_b;
  logic [4:0] countval_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dsc_par_acc #(.LANES(8), .WIDTH(10), .WIN_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .data_in(data_in),
    .in_valid(in_valid), .res_ready(res_ready), .busy(busy_a), .res_valid(res_valid_a),
    .countval(countval_a), .overflow(overflow_a)
  );

  dsc_par_acc #(.LANES(8), .WIDTH(5), .WIN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .data_in(data_in),
    .in_valid(in_valid), .res_ready(res_ready), .busy(busy_b), .res_valid(res_valid_b),
    .countval(countval_b), .overflow(overflow_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: ones total over the window, then wrap or clamp to w bits.
  function automatic longint ref_cnt(input longint sum, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    if (sum <= top) return sum;
`ifdef DSC_ACC_SAT_EN
    return top;
`else
    return sum % (top + 1);
`endif
  endfunction

  function automatic longint ref_ovf(input longint sum, input int w);
    return (sum > ((longint'(1) << w) - 1)) ? 1 : 0;
  endfunction

  // Opens a window and feeds wl samples with `gap` idle cycles after each.
  // lat counts edges from the start-accepting edge (inclusive) to res_valid.
  task automatic run_window(input int wl, input int gap, input bit fixed, input logic [7:0] dfix,
                            input bit rnd_start, output longint sum, output int lat,
                            output bit st_busy);
    int edges;
    logic [7:0] d;
    sum = 0;
    start = 1'b1;
    win_len = wl[7:0];
    tick();
    start = 1'b0;
    edges = 1;
    st_busy = busy_a;
    for (int i = 0; i < wl; i++) begin
      d = fixed ? dfix : 8'($urandom);
      in_valid = 1'b1;
      data_in = d;
      sum += $countones(d);
      if (rnd_start) begin
        start = 1'($urandom);
        win_len = 8'($urandom);
      end
      tick();
      edges++;
      in_valid = 1'b0;
      start = 1'b0;
      for (int g = 0; g < gap; g++) begin
        data_in = 8'($urandom);
        tick();
        edges++;
      end
    end
    data_in = 8'($urandom);
    in_valid = 1'($urandom);
    for (int k = 0; k < 20 && !res_valid_a; k++) begin
      tick();
      edges++;
    end
    in_valid = 1'b0;
    lat = res_valid_a ? edges : -1;
    chk("res_valid_timeout", res_valid_a, 1);
  endtask

  // Holds res_ready low for `hold` cycles, then releases (optionally with start high).
  task automatic hold_release(input int hold, input bit rel_start, input string tag);
    logic [9:0] ca;
    logic [4:0] cb;
    bit stable;
    ca = countval_a;
    cb = countval_b;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (countval_a !== ca || countval_b !== cb || res_valid_a !== 1'b1 || res_valid_b !== 1'b1)
        stable = 1'b0;
    end
    if (hold > 1) chk({tag, "_hold_stable"}, stable, 1);
    res_ready = 1'b1;
    start = rel_start;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_idle_busy"}, busy_a, 0);
    chk({tag, "_idle_res_valid"}, res_valid_a, 0);
    tick();
    chk({tag, "_idle_keep_count"}, countval_a, ca);
    chk({tag, "_idle_still_idle"}, busy_a, 0);
  endtask

  typedef struct {
    int         wl;
    logic [7:0] d;
    int         gap;
    int         hold;
    int         c10w, c10s, o10;
    int         c5w, c5s, o5;
  } vec_t;

  initial begin
    vec_t   tbl[7];
    longint sum;
    int     lat;
    bit     st_busy;
    longint e10, e5;

    tbl[0] = '{4,   8'hFF, 0, 1,  32,   32,   0, 0,  31, 1};
    tbl[1] = '{3,   8'h0F, 1, 1,  12,   12,   0, 12, 12, 0};
    tbl[2] = '{5,   8'hFF, 0, 1,  40,   40,   0, 8,  31, 1};
    tbl[3] = '{0,   8'hAA, 0, 10, 0,    0,    0, 0,  0,  0};
    tbl[4] = '{1,   8'h01, 0, 2,  1,    1,    0, 1,  1,  0};
    tbl[5] = '{255, 8'hFF, 0, 3,  1016, 1023, 1, 24, 31, 1};
    tbl[6] = '{2,   8'h00, 2, 1,  0,    0,    0, 0,  0,  0};

    tick();
    tick();
    chk("reset_busy", busy_a, 0);
    chk("reset_res_valid", res_valid_a, 0);
    chk("reset_countval", countval_a, 0);
    chk("reset_overflow", overflow_a, 0);
    rst = 1'b0;

    for (int r = 0; r < 7; r++) begin
      run_window(tbl[r].wl, tbl[r].gap, 1'b1, tbl[r].d, 1'b0, sum, lat, st_busy);
      chk($sformatf("vec%0d_busy_after_start", r), st_busy, 1);
`ifdef DSC_ACC_SAT_EN
      e10 = tbl[r].c10s;
      e5  = tbl[r].c5s;
`else
      e10 = tbl[r].c10w;
      e5  = tbl[r].c5w;
`endif
      chk($sformatf("vec%0d_countval_w10", r), countval_a, e10);
      chk($sformatf("vec%0d_overflow_w10", r), overflow_a, tbl[r].o10);
      chk($sformatf("vec%0d_countval_w5", r), countval_b, e5);
      chk($sformatf("vec%0d_overflow_w5", r), overflow_b, tbl[r].o5);
      chk($sformatf("vec%0d_res_valid_w5", r), res_valid_b, 1);
      if (tbl[r].gap == 0)
        chk($sformatf("vec%0d_latency", r), lat, (tbl[r].wl == 0) ? 1 : tbl[r].wl + 2);
      hold_release(tbl[r].hold, 1'b0, $sformatf("vec%0d", r));
    end

    // Reset mid-window, then the very next edge must honour a start.
    start = 1'b1;
    win_len = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    data_in = 8'hFF;
    tick();
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_res_valid", res_valid_a, 0);
    chk("midrst_countval", countval_a, 0);
    chk("midrst_overflow", overflow_a, 0);
    chk("midrst_countval_w5", countval_b, 0);
    #1 rst = 1'b0;
    run_window(2, 0, 1'b1, 8'h01, 1'b0, sum, lat, st_busy);
    chk("postrst_start_honoured", st_busy, 1);
    chk("postrst_countval", countval_a, 2);
    chk("postrst_latency", lat, 4);
    hold_release(1, 1'b1, "postrst");

    // Random windows against the reference model, with spurious starts.
    for (int t = 0; t < 25; t++) begin
      int wl, gap;
      wl = $urandom_range(0, 40);
      gap = $urandom_range(0, 2);
      run_window(wl, gap, 1'b0, 8'h00, 1'b1, sum, lat, st_busy);
      chk($sformatf("rnd%0d_countval_w10", t), countval_a, ref_cnt(sum, 10));
      chk($sformatf("rnd%0d_overflow_w10", t), overflow_a, ref_ovf(sum, 10));
      chk($sformatf("rnd%0d_countval_w5", t), countval_b, ref_cnt(sum, 5));
      chk($sformatf("rnd%0d_overflow_w5", t), overflow_b, ref_ovf(sum, 5));
      hold_release($urandom_range(1, 4), 1'($urandom), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dsc_par_acc.md
DSC_PAR_ACC -- requirements
Module: dsc_par_acc

Interface
REQ-001 SHALL have parameter LANES, default 8, number of stochastic bit lanes summed per sample (1..64).
REQ-002 SHALL have parameter WIDTH, default 10, accumulator width in bits; WIDTH SHALL be >= CLOG2(LANES+1).
REQ-003 SHALL have parameter WIN_W, default 8, width of the window-length field.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to begin a new accumulation window.
REQ-007 SHALL have port win_len  input  WIN_W  number of valid samples in the window; captured on start acceptance.
REQ-008 SHALL have port data_in  input  LANES  one stochastic bit per lane.
REQ-009 SHALL have port in_valid  input  1  data_in carries a sample this cycle.
REQ-010 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port res_valid  output  1  result valid; high only in HOLD.
REQ-013 SHALL have port countval  output  WIDTH  accumulated ones count.
REQ-014 SHALL have port overflow  output  1  sticky; set if the true sum exceeded 2^WIDTH-1 in the current window.

Function
REQ-015 SHALL implement states IDLE, ACC, DRAIN, HOLD.
REQ-016 IDLE: start=1 SHALL load remaining=win_len, clear countval, overflow and the popcount register, then go to ACC, or to HOLD if win_len=0.
REQ-017 start SHALL be ignored in ACC, DRAIN and HOLD.
REQ-018 ACC: each edge with in_valid=1 SHALL register popcount(data_in) (width CLOG2(LANES+1)), set a pending flag and decrement remaining.
REQ-019 ACC: each edge SHALL add the previously registered popcount to countval when pending was set; cycles with in_valid=0 SHALL add nothing and leave remaining unchanged.
REQ-020 ACC: the edge accepting the sample that brings remaining to 0 SHALL go to DRAIN.
REQ-021 DRAIN: the next edge SHALL add the final registered popcount and go to HOLD unconditionally; in_valid SHALL be ignored in DRAIN.
REQ-022 Latency: with in_valid held high, res_valid SHALL rise win_len+2 edges after the start-accepting edge.
REQ-023 HOLD: res_valid=1 and countval/overflow SHALL stay stable until an edge with res_ready=1, which SHALL return to IDLE.
REQ-024 HOLD with res_ready=1 and start=1 on the same edge SHALL return to IDLE only; start SHALL be re-asserted to open the next window.
REQ-025 In IDLE, countval and overflow SHALL keep the last result until the next start is accepted.
REQ-026 Addition SHALL be computed WIDTH+1 bits wide; a carry into bit WIDTH SHALL set overflow.

Reset
REQ-027 Asserting rst in any state, including mid-window, SHALL immediately force IDLE, countval=0, overflow=0, res_valid=0, busy=0, remaining=0, popcount register=0 and pending=0.
REQ-028 The first start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro DSC_ACC_SAT_EN SHALL select overflow handling.
REQ-030 With DSC_ACC_SAT_EN defined, countval SHALL clamp at 2^WIDTH-1 and hold there for the rest of the window; overflow SHALL set.
REQ-031 Without DSC_ACC_SAT_EN, countval SHALL wrap modulo 2^WIDTH; overflow SHALL still set.

Verification (LANES=8, WIDTH=10 unless stated)
REQ-032 win_len=4, in_valid=1, data_in=8'hFF -> res_valid high 6 edges after start, countval=32, overflow=0.
REQ-033 win_len=3, in_valid pattern 1,0,1,0,1, data_in=8'h0F -> countval=12; remaining decrements only on valid cycles.
REQ-034 WIDTH=5, win_len=5, data_in=8'hFF -> without macro countval=8, overflow=1; with DSC_ACC_SAT_EN countval=31, overflow=1.
REQ-035 win_len=0 -> HOLD on the next edge with countval=0; res_ready held low 10 cycles -> countval and res_valid stable throughout.
REQ-036 rst pulsed after 2 of 4 samples -> all outputs 0 and state IDLE at once; a new window with win_len=2, data_in=8'h01 -> countval=2.
